signed_divider: RTL and testbench

- Sequential N-bit two's-complement divider: computes quotient and remainder of `data_Q / data_M` by restoring shift-subtract over magnitudes, then applies a sign fix-up.
- Inverse companion of the Booth multiplier: the same N, the same operand port names, and a packed `data_out` result bus.
- Used to undo or scale products, and sits beside the multiplier on the same operand/result buses.

---
 rtl/divider_pkg.sv | 28 ++
 rtl/div_datapath.sv | 99 +++++++++
 rtl/signed_divider.sv | 122 ++++++++++++
 tb/tb_signed_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the signed restoring divider.
//   - div_state_t : controller state encoding (IDLE, ITER, FIX, DONE)
//   - ST_*        : raw encodings, usable by checkers that only see bits
//   - SABS_W      : widest operand the magnitude helper supports
//   - sabs()      : two's-complement magnitude of a sign-extended value
package divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ITER = ST_ITER,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } div_state_t;

    localparam int SABS_W = 32;

    // Magnitude of a sign-extended value. The most negative N-bit operand
    // maps to 2^(N-1), which still fits in N unsigned bits once truncated.
    function automatic logic [SABS_W-1:0] sabs(input logic signed [SABS_W-1:0] v);
        return v[SABS_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_datapath.sv
// div_datapath: restoring shift-subtract engine over operand magnitudes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_load            : capture signs/magnitudes, clear A, counter <= N
//   i_step            : one restoring iteration, counter decrements
//   i_fix             : enables the signed result outputs
//   i_zload           : divide-by-zero accept, clears the engine
//   i_data_q, i_data_m: dividend / divisor (signed, sampled on i_load)
//   o_cnt_z           : the current step brings the counter to zero
//   o_quot, o_rem     : sign-corrected quotient / remainder (valid with i_fix)
//   o_ovf             : quotient overflowed (-2^(N-1) / -1), valid with i_fix
module div_datapath
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_fix,
    input  logic         i_zload,
    input  logic [N-1:0] i_data_q,
    input  logic [N-1:0] i_data_m,
    output logic         o_cnt_z,
    output logic [N-1:0] o_quot,
    output logic [N-1:0] o_rem,
    output logic         o_ovf
);

    localparam int CW = $clog2(N + 1);

    logic [N:0]    r_a;
    logic [N-1:0]  r_qr;
    logic [N-1:0]  r_mr;
    logic [CW-1:0] r_cnt;
    logic          r_sq;
    logic          r_sm;

    logic [N-1:0]  w_q_mag;
    logic [N-1:0]  w_m_mag;
    logic [2*N:0]  w_aq_sh;
    logic [N:0]    w_a_sh;
    logic [N-1:0]  w_qr_sh;
    logic [N:0]    w_trial;
    logic [N-1:0]  w_quot_fix;
    logic [N-1:0]  w_rem_fix;

    assign w_q_mag = N'(sabs(SABS_W'($signed(i_data_q))));
    assign w_m_mag = N'(sabs(SABS_W'($signed(i_data_m))));

    // Shift the concatenated {A,Qr} pair left by one as a single register.
    assign w_aq_sh = {r_a, r_qr} << 1;
    assign w_a_sh  = w_aq_sh[2*N:N];
    assign w_qr_sh = w_aq_sh[N-1:0];
    assign w_trial = w_a_sh - {1'b0, r_mr};

    always_ff @(posedge clk) begin
        if (rst || i_zload) begin
            r_a   <= '0;
            r_qr  <= '0;
            r_mr  <= '0;
            r_cnt <= '0;
            r_sq  <= 1'b0;
            r_sm  <= 1'b0;
        end else if (i_load) begin
            r_sq  <= i_data_q[N-1];
            r_sm  <= i_data_m[N-1];
            r_qr  <= w_q_mag;
            r_mr  <= w_m_mag;
            r_a   <= '0;
            r_cnt <= CW'(N);
        end else if (i_step) begin
            // Negative trial: restore (keep shifted A), quotient bit 0.
            if (w_trial[N]) begin
                r_a  <= w_a_sh;
                r_qr <= w_qr_sh;
            end else begin
                r_a  <= w_trial;
                r_qr <= w_qr_sh | N'(1);
            end
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Asserted during the last iteration so the controller leaves ITER
    // on the same edge that takes the counter to zero.
    assign o_cnt_z = (r_cnt == CW'(1));

    assign w_quot_fix = (r_sq ^ r_sm) ? -r_qr : r_qr;
    assign w_rem_fix  = r_sq ? -r_a[N-1:0] : r_a[N-1:0];

    assign o_quot = i_fix ? w_quot_fix : '0;
    assign o_rem  = i_fix ? w_rem_fix  : '0;
    // A quotient magnitude of 2^(N-1) with a positive result sign is only
    // reachable from -2^(N-1) / -1; it wraps back to -2^(N-1).
    assign o_ovf  = i_fix && !(r_sq ^ r_sm) && (r_qr == {1'b1, {(N-1){1'b0}}});

endmodule

// File: rtl/signed_divider.sv
// signed_divider: sequential N-bit two's-complement divider (truncating).
// Handshake: start is accepted only in IDLE or DONE; done is a one-cycle
// pulse marking data_out/dz/ovf valid; busy is high while an accepted
// divide is in flight and start is ignored then.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : divide request
//   data_Q, data_M : dividend / divisor, signed, sampled on accept
//   busy, done     : status
//   dz, ovf        : divide-by-zero / overflow flags for last operation
//   data_out       : {remainder, quotient}, held until next accepted start
//   dbg_state      : controller state, for observation
module signed_divider
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   data_Q,
    input  logic [N-1:0]   data_M,
    output logic           busy,
    output logic           done,
    output logic           dz,
    output logic           ovf,
    output logic [2*N-1:0] data_out,
    output div_state_t     dbg_state
);

    div_state_t     r_state;
    div_state_t     w_state_nxt;
    logic           w_load;
    logic           w_step;
    logic           w_fix;
    logic           w_zload;
    logic           w_cnt_z;
    logic [N-1:0]   w_quot;
    logic [N-1:0]   w_rem;
    logic           w_ovf;

    logic [2*N-1:0] r_data_out;
    logic           r_dz;
    logic           r_ovf;

    div_datapath #(.N(N)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_zload  (w_zload),
        .i_data_q (data_Q),
        .i_data_m (data_M),
        .o_cnt_z  (w_cnt_z),
        .o_quot   (w_quot),
        .o_rem    (w_rem),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        w_zload     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (start) begin
                    if (data_M == '0) begin
                        w_zload     = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ITER;
                    end
                end
            end
            ITER: begin
                w_step = 1'b1;
                if (w_cnt_z) w_state_nxt = FIX;
            end
            FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_zload) begin
            r_data_out <= {data_Q, {N{1'b1}}};
            r_dz       <= 1'b1;
            r_ovf      <= 1'b0;
        end else if (w_load) begin
            r_dz  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_fix) begin
            r_data_out <= {w_rem, w_quot};
            r_ovf      <= w_ovf;
        end
    end

    assign busy      = (r_state == ITER) || (r_state == FIX);
    assign done      = (r_state == DONE);
    assign dz        = r_dz;
    assign ovf       = r_ovf;
    assign data_out  = r_data_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_signed_divider.sv
module tb_signed_divider;
    import divider_pkg::*;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   data_Q;
    logic [N-1:0]   data_M;
    logic           busy;
    logic           done;
    logic           dz;
    logic           ovf;
    logic [2*N-1:0] data_out;
    div_state_t     dbg_state;

    signed_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_Q    (data_Q),
        .data_M    (data_M),
        .busy      (busy),
        .done      (done),
        .dz        (dz),
        .ovf       (ovf),
        .data_out  (data_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2*N-1:0] d;
        logic           edz;
        logic           eovf;
        int             ecyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_exp(input logic [2*N-1:0] d, input logic edz, input logic eovf, input int ecyc);
        exp_t e;
        e.d    = d;
        e.edz  = edz;
        e.eovf = eovf;
        e.ecyc = ecyc;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e.d));
                chk("dz", 32'(dz), 32'(mon_e.edz));
                chk("ovf", 32'(ovf), 32'(mon_e.eovf));
                chk("done_cycle", 32'(cyc), 32'(mon_e.ecyc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [N-1:0] q, input logic [N-1:0] m,
                         input logic [2*N-1:0] d, input logic edz, input logic eovf);
        @(negedge clk);
        start  = 1'b1;
        data_Q = q;
        data_M = m;
        push_exp(d, edz, eovf, cyc + ((m == '0) ? 1 : N + 2));
        @(negedge clk);
        start  = 1'b0;
        data_Q = N'($urandom_range(0, 15));
        data_M = N'($urandom_range(0, 15));
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d pending results want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_dz"}, 32'(dz), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        data_Q = '0;
        data_M = '0;
        idle_cycles(3);
        chk_zero_outputs("reset");
        rst = 1'b0;
        idle_cycles(1);
        chk_zero_outputs("post_reset");

        // 7 / 2 with busy profile: busy in cycles 1..5, low in cycle 6
        issue(4'h7, 4'h2, 8'h13, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk("busy_iter", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("busy_done", 32'(busy), 32'd0);
        wait_empty();

        // signed cases
        issue(4'h9, 4'h2, 8'hFD, 1'b0, 1'b0);   // -7 /  2
        wait_empty();
        issue(4'h7, 4'hE, 8'h1D, 1'b0, 1'b0);   //  7 / -2
        wait_empty();
        issue(4'h9, 4'hE, 8'hF3, 1'b0, 1'b0);   // -7 / -2
        wait_empty();

        // most-negative dividend boundaries
        issue(4'h8, 4'hF, 8'h08, 1'b0, 1'b1);   // -8 / -1 overflow
        wait_empty();
        issue(4'h8, 4'h1, 8'h08, 1'b0, 1'b0);   // -8 /  1
        wait_empty();
        issue(4'h8, 4'h2, 8'h0C, 1'b0, 1'b0);   // -8 /  2
        wait_empty();
        issue(4'h3, 4'h8, 8'h30, 1'b0, 1'b0);   //  3 / -8
        wait_empty();

        // divide by zero, then a normal divide clears dz
        issue(4'h5, 4'h0, 8'h5F, 1'b1, 1'b0);
        wait_empty();
        issue(4'h6, 4'h3, 8'h02, 1'b0, 1'b0);
        wait_empty();

        // reset mid-operation: no done, outputs zeroed
        @(negedge clk);
        start  = 1'b1;
        data_Q = 4'h7;
        data_M = 4'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;           // dropped: reset wins
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk_zero_outputs("abort");
        idle_cycles(8);
        issue(4'h6, 4'h3, 8'h02, 1'b0, 1'b0);
        wait_empty();

        // start held high: back-to-back results every N+2 cycles
        @(negedge clk);
        start  = 1'b1;
        data_Q = 4'h7;
        data_M = 4'h2;
        push_exp(8'h13, 1'b0, 1'b0, cyc + N + 2);
        idle_cycles(N + 2);
        data_Q = 4'h6;
        data_M = 4'hC;          //  6 / -4
        push_exp(8'h2F, 1'b0, 1'b0, cyc + N + 2);
        idle_cycles(N + 2);
        data_Q = 4'hB;          // -5 / 3
        data_M = 4'h3;
        push_exp(8'hEF, 1'b0, 1'b0, cyc + N + 2);
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        idle_cycles(2);

        // start pulsed during ITER is ignored
        issue(4'h7, 4'h2, 8'h13, 1'b0, 1'b0);
        start  = 1'b1;
        data_Q = 4'h1;
        data_M = 4'h1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        idle_cycles(8);
        chk("held_result", 32'(data_out), 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
